gray_code_pipe: RTL and testbench
=================================

// Module: gray_code_pipe
// PURPOSE
// - Multi-channel, pipelined, bidirectional Gray/binary converter with a valid/ready stream handshake.
// - Successor to the single-register Gray decoder; converts CHANNELS independent words per beat.
// - Each beat carries a mode bit selecting decode (Gray->bin) or encode (bin->Gray).
// - Sits behind CDC pointer/timestamp synchronisers; feeds FIFO occupancy logic and timestamp logic.
// PARAMETERS
// - WIDTH        32  bits per channel word (>=2)
// - CHANNELS     1   independent words per beat (>=1)
// - PIPE_STAGES  2   register stages, input to output (>=1, <=WIDTH); the decode XOR-prefix chain is split across them
// PORTS
// - clk         in   1                 clock; all logic rising-edge
// - rst_n       in   1                 asynchronous active-low reset
// - s_valid     in   1                 input beat valid
// - s_ready     out  1                 input beat accepted when s_valid&s_ready
// - s_mode      in   1                 0 = Gray->bin, 1 = bin->Gray
// - s_data      in   CHANNELS*WIDTH    channel c at [c*WIDTH +: WIDTH]
// - m_valid     out  1                 output beat valid
// - m_ready     in   1                 downstream accept
// - m_mode      out  1                 mode the beat was converted with
// - m_data      out  CHANNELS*WIDTH    converted words, same channel packing
// - err         out  CHANNELS          sticky per-channel Gray step error (see CONFIGURATION)
// - err_clr     in   1                 synchronous clear of err, all channels
// BEHAVIOUR
// - Reset (async assert, sync-released by caller): all stage valid bits=0, m_valid=0, m_data=0, m_mode=0, err=0; s_ready=1 one cycle after release.
// - Decode: bin[i] = ^gray[WIDTH-1:i]. Encode: gray = bin ^ (bin>>1). Per channel, no cross-channel terms.
// - Latency: a beat accepted at edge N is visible on m_* after edge N+PIPE_STAGES when there is no stall.
// - Pipeline: each stage holds {valid, mode, partial data}. A stage loads when it is empty or when its downstream stage empties or advances in the same cycle.
//   - Bubbles collapse. Full throughput of 1 beat/cycle with m_ready=1.
// - s_ready = ~stage0_valid | stage0_advances. It is combinational from m_ready through the advance chain.
//   - Fully-registered ready is not required.
// - m_valid/m_data/m_mode hold stable while m_valid&~m_ready. Data changes only on a transfer or into an empty output stage.
// - Per-stage split for decode: stage s resolves the next ceil(WIDTH/PIPE_STAGES) bits, MSB-first.
//   - It forwards the running XOR plus unresolved Gray bits. Encode resolves fully in stage 0 and is just delayed.
// - Mixed-mode beats may be back-to-back. Mode travels with its beat; there is no drain on a mode change.
// - Simultaneous accept and emit in one cycle is legal and expected.
// - Reset mid-operation: all in-flight beats are discarded. No output appears for beats accepted before reset.
// - err_clr has priority over a same-cycle error set. err is unaffected by stalls.
// CONFIGURATION
// - Macro GRAY_CODE_PIPE_STEP_CHECK_EN.
// - Defined:
//   - Per channel, store the last accepted mode-0 input word plus a seen flag; both reset to 0.
//   - On each mode-0 acceptance with seen=1, if popcount(new ^ last) > 1, set err[c]. Equal words (0 bits changed) are legal.
//   - Update last on every mode-0 acceptance. Mode-1 beats are neither checked nor stored.
//   - Wrap-around from {1,0..0} to 0 is a 1-bit step and is legal.
// - Not defined: no checker storage; err is tied to 0 and err_clr is ignored. Datapath and timing are identical.
// TESTING
// - WIDTH=4,CH=1,PIPE=2: s_mode=0, s_data=4'b1101 -> m_data=4'b1001, m_mode=0, exactly 2 cycles after accept.
// - Same config: s_mode=1, s_data=4'b1001 -> 4'b1101. Alternate modes on 16 back-to-back beats, m_ready=1 -> 16 outputs, no gaps, modes preserved.
// - WIDTH=8,CH=3: exhaustive 0..255 encode-then-decode loopback on all channels, random m_ready toggling.
//   - -> all values round-trip, no drops or duplicates, m_* stable during stalls.
// - Fill pipe with m_ready=0 -> s_ready=0 after PIPE_STAGES+1 beats. Release m_ready -> beats emerge in order, then s_ready=1.
// - Assert rst_n low with 2 beats in flight -> m_valid=0 immediately. After release, no stale beat is emitted.
// - STEP_CHECK_EN, ch0 Gray 8'h00 -> 8'h03 -> err[0]=1. 8'h00->8'h01->8'h01 -> err=0. err_clr together with a bad step -> err stays 0.

Source files
------------

// File: rtl/gray_code_pipe.sv
// Multi-channel pipelined Gray<->binary converter with valid/ready handshake.
// Optional sticky Gray step checker: define GRAY_CODE_PIPE_STEP_CHECK_EN.
module gray_code_pipe #(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      s_mode,
  input  logic [CHANNELS*WIDTH-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_mode,
  output logic [CHANNELS*WIDTH-1:0] m_data,
  output logic [CHANNELS-1:0]       err,
  input  logic                      err_clr
);

  // Stages 0..PIPE_STAGES-1 resolve decode slices; the last stage is the output register.
  localparam int NS = PIPE_STAGES + 1;
  localparam int SL = (WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;

  logic [NS-1:0]                          r_vld, r_mode;
  logic [NS-1:0][CHANNELS-1:0][WIDTH-1:0] r_dat;
  logic [NS-1:0][CHANNELS-1:0][WIDTH-1:0] w_nxt;
  logic [NS-1:0]                          w_load, w_in_vld, w_in_mode;

  // Word holds binary above the slice and Gray below; bin[i] = bin[i+1] ^ gray[i].
  function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] w, input int s);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = WIDTH - 2; i >= 0; i--)
      if (i < WIDTH - s * SL && i >= WIDTH - (s + 1) * SL) r[i] = r[i+1] ^ r[i];
    return r;
  endfunction

  genvar s, c;
  generate
    for (s = 0; s < NS; s++) begin : g_stage
      // A stage may load if any stage at or after it is empty, or the output drains.
      assign w_load[s] = m_ready | ~(&r_vld[NS-1:s]);
      if (s == 0) begin : g_in
        assign w_in_vld[s]  = s_valid;
        assign w_in_mode[s] = s_mode;
        for (c = 0; c < CHANNELS; c++) begin : g_ch
          logic [WIDTH-1:0] w_b;
          assign w_b         = s_data[c*WIDTH +: WIDTH];
          assign w_nxt[s][c] = s_mode ? (w_b ^ (w_b >> 1)) : resolve(w_b, 0);
        end
      end else begin : g_mid
        assign w_in_vld[s]  = r_vld[s-1];
        assign w_in_mode[s] = r_mode[s-1];
        for (c = 0; c < CHANNELS; c++) begin : g_ch
          assign w_nxt[s][c] = r_mode[s-1] ? r_dat[s-1][c] : resolve(r_dat[s-1][c], s);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_mode <= '0;
      r_dat  <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= w_in_vld[k];
          if (w_in_vld[k]) begin
            r_mode[k] <= w_in_mode[k];
            r_dat[k]  <= w_nxt[k];
          end
        end
      end
    end
  end

  assign s_ready = w_load[0];
  assign m_valid = r_vld[NS-1];
  assign m_mode  = r_mode[NS-1];
  assign m_data  = r_dat[NS-1];

`ifdef GRAY_CODE_PIPE_STEP_CHECK_EN
  logic [CHANNELS-1:0][WIDTH-1:0] r_last;
  logic                           r_seen;
  logic [CHANNELS-1:0]            r_err;
  logic                           w_acc0;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  function automatic logic multibit(input logic [WIDTH-1:0] x);
    return (x & (x - WIDTH'(1))) != '0;
  endfunction

  assign w_acc0 = s_valid & s_ready & ~s_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
      r_seen <= 1'b0;
      r_err  <= '0;
    end else begin
      if (w_acc0) begin
        r_last <= s_data;
        r_seen <= 1'b1;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (err_clr) r_err[k] <= 1'b0;
        else if (w_acc0 && r_seen && multibit(s_data[k*WIDTH +: WIDTH] ^ r_last[k]))
          r_err[k] <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = err_clr;
  assign err      = '0;
`endif

endmodule

// File: tb/tb_gray_code_pipe.sv
// Self-checking bench for gray_code_pipe (WIDTH=8, CHANNELS=3, PIPE_STAGES=2).
module tb_gray_code_pipe;
  localparam int W  = 8;
  localparam int CH = 3;
  localparam int P  = 2;
`ifdef GRAY_CODE_PIPE_STEP_CHECK_EN
  localparam logic [CH-1:0] ERR_BAD = '1;
`else
  localparam logic [CH-1:0] ERR_BAD = '0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_mode = 1'b0, err_clr = 1'b0;
  logic s_ready, m_valid, m_mode;
  logic m_ready = 1'b1;
  logic [CH*W-1:0] s_data = '0, m_data;
  logic [CH-1:0] err;

  gray_code_pipe #(.WIDTH(W), .CHANNELS(CH), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_mode(m_mode),
    .m_data(m_data), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic mode; logic [CH*W-1:0] data;} exp_t;
  typedef struct {logic mode; logic [W-1:0] din; logic [W-1:0] dout;} vec_t;

  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, xfer_cnt = 0, first_x = 0, last_x = 0, retries = 0;
  logic rnd_rdy = 1'b0, rdy_val = 1'b1;
  logic prev_stall = 1'b0, prev_mode;
  logic [CH*W-1:0] prev_data;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Scoreboard: pop on every transfer, and check outputs hold during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        n_tests++;
        if (!m_valid || m_data !== prev_data || m_mode !== prev_mode) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b d=%h m=%b expected v=1 d=%h m=%b",
                   m_valid, m_data, m_mode, prev_data, prev_mode);
        end
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got d=%h m=%b expected none", m_data, m_mode);
        end else begin
          e = q.pop_front();
          n_tests++;
          if (m_data !== e.data || m_mode !== e.mode) begin
            n_fail++;
            $display("FAIL beat: got d=%h m=%b expected d=%h m=%b", m_data, m_mode, e.data, e.mode);
          end
          xfer_cnt++;
          if (xfer_cnt == 1) first_x = cyc;
          last_x = cyc;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_mode  = m_mode;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic md, input logic [CH*W-1:0] d, input logic [CH*W-1:0] ex);
    bit done;
    done = 0;
    s_valid = 1'b1; s_mode = md; s_data = d;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        q.push_back('{mode: md, data: ex});
        done = 1;
      end else retries++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic dec1(input logic [W-1:0] g);
    send(1'b0, {CH{g}}, {CH{g2b(g)}});
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    vec_t tv[9];
    logic [CH*W-1:0] d, ex;
    int acc, vcnt;
    tv[0] = '{1'b0, 8'h0D, 8'h09};  tv[1] = '{1'b1, 8'h09, 8'h0D};
    tv[2] = '{1'b0, 8'hFF, 8'hAA};  tv[3] = '{1'b1, 8'hFF, 8'h80};
    tv[4] = '{1'b0, 8'h80, 8'hFF};  tv[5] = '{1'b1, 8'h00, 8'h00};
    tv[6] = '{1'b0, 8'h01, 8'h01};  tv[7] = '{1'b1, 8'hAA, 8'hFF};
    tv[8] = '{1'b0, 8'h03, 8'h02};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_mode", m_mode, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 1);

    // Latency: visible after accept edge + 2
    s_valid = 1'b1; s_mode = 1'b0; s_data = {CH{8'h0D}};
    @(negedge clk);
    chk("lat_s_ready", s_ready, 1);
    q.push_back('{mode: 1'b0, data: {CH{8'h09}}});
    @(posedge clk); #1; s_valid = 1'b0;
    chk("lat_edge0", m_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge1", m_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", m_valid, 1);
    chk("lat_edge2_data", m_data, {CH{8'h09}});
    chk("lat_edge2_mode", m_mode, 0);
    drain();

    // Table vectors
    foreach (tv[i]) send(tv[i].mode, {CH{tv[i].din}}, {CH{tv[i].dout}});
    drain();

    // 16 back-to-back alternating modes, no gaps
    xfer_cnt = 0; retries = 0;
    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] v;
      v = W'(k * 17 + 3);
      if (k % 2 == 0) send(1'b0, {CH{v}}, {CH{g2b(v)}});
      else            send(1'b1, {CH{v}}, {CH{b2g(v)}});
    end
    drain();
    chk("b2b_count", xfer_cnt, 16);
    chk("b2b_span", last_x - first_x, 15);
    chk("b2b_retries", retries, 0);

    // Exhaustive loopback on all channels with random backpressure
    rnd_rdy = 1'b1;
    for (int v = 0; v < 256; v++) begin
      for (int c = 0; c < CH; c++) begin
        logic [W-1:0] w;
        w = W'(v + 85 * c);
        d[c*W +: W] = w; ex[c*W +: W] = b2g(w);
      end
      send(1'b1, d, ex);
      send(1'b0, ex, d);
    end
    drain();
    rnd_rdy = 1'b0; rdy_val = 1'b1;
    @(posedge clk); #1;

    // Fill with m_ready low
    rdy_val = 1'b0;
    @(posedge clk); #1;
    acc = 0;
    s_valid = 1'b1; s_mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data = {CH{W'(k + 1)}};
      @(negedge clk);
      if (!s_ready) break;
      q.push_back('{mode: 1'b1, data: {CH{b2g(W'(k + 1))}}});
      acc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("fill_accepted", acc, P + 1);
    chk("fill_s_ready", s_ready, 0);
    rdy_val = 1'b1;
    drain();
    @(posedge clk); #1;
    chk("fill_release_s_ready", s_ready, 1);

    // Reset with two beats in flight
    rdy_val = 1'b0;
    @(posedge clk); #1;
    dec1(8'h0D);
    dec1(8'hFF);
    @(posedge clk); #1;
    chk("midrst_pre_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    q.delete();
    rdy_val = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_valid) vcnt++;
    end
    chk("midrst_no_stale", vcnt, 0);
    @(posedge clk); #1;

    // Step checker
    dec1(8'h00); clr_pulse(); dec1(8'h03);
    chk("step_00_03", err, ERR_BAD);
    dec1(8'h00); clr_pulse(); dec1(8'h01); dec1(8'h01);
    chk("step_00_01_01", err, 0);
    dec1(8'h80); clr_pulse(); dec1(8'h00);
    chk("step_wrap", err, 0);
    dec1(8'h00); clr_pulse();
    err_clr = 1'b1; dec1(8'h03); err_clr = 1'b0;
    chk("step_clr_priority", err, 0);
    dec1(8'h00);
    chk("step_03_00", err, ERR_BAD);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
